tile_pixel_renderer: RTL and testbench

TILE_PIXEL_RENDERER -- requirements
Module: tile_pixel_renderer

---
 rtl/tile_pixel_renderer.sv | 119 +++++++++++
 tb/tb_tile_pixel_renderer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pixel_renderer.sv
// Tile pixel renderer: picks a bitmap bit per pixel and colours it by tile type, with a frame-rate blink.
// Latency: 2 pix_en ticks from the address-cycle inputs to rgb_o / hsync_o / vsync_o.
// No backpressure: all state advances only on pix_en_i and holds otherwise.
module tile_pixel_renderer #(
    parameter int RAM_DATA_WIDTH = 7,
    parameter int ROM_DATA_WIDTH = 32,
    parameter int COLOR_WIDTH    = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      pix_en_i,
    input  logic                      video_on_i,
    input  logic                      hsync_i,
    input  logic                      vsync_i,
    input  logic [4:0]                h_cntr_mod32_i,
    input  logic [RAM_DATA_WIDTH-1:0] tile_type_i,
    input  logic [ROM_DATA_WIDTH-1:0] rom_data_i,
    output logic [COLOR_WIDTH-1:0]    rgb_o,
    output logic                      hsync_o,
    output logic                      vsync_o
);

    localparam logic [COLOR_WIDTH-1:0] COL_RED   = COLOR_WIDTH'(12'hF00);
    localparam logic [COLOR_WIDTH-1:0] COL_BLUE  = COLOR_WIDTH'(12'h00F);
    localparam logic [COLOR_WIDTH-1:0] COL_WHITE = COLOR_WIDTH'(12'hFFF);
    localparam logic [COLOR_WIDTH-1:0] COL_BLACK = '0;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_RED,
        CLS_BLUE,
        CLS_WHITE
    } tile_class_e;

    // Stage 1: address-cycle controls, aligned with rom_data_i
    logic                      s1_video_on;
    logic                      s1_hsync;
    logic                      s1_vsync;
    logic [4:0]                s1_col;
    logic [RAM_DATA_WIDTH-1:0] s1_type;

    logic [5:0]                frame_cnt;
    logic                      vsync_prev;

    logic [ROM_DATA_WIDTH-1:0] row_shifted;
    logic                      pix_bit;
    logic                      blink_off;
    tile_class_e               s1_class;
    logic                      s1_blinkable;
    logic [COLOR_WIDTH-1:0]    rgb_next;

    function automatic tile_class_e classify(input logic [RAM_DATA_WIDTH-1:0] t);
        int unsigned v;
        v = int'(t);
        if ((v >= 2 && v <= 6) || (v >= 32 && v <= 39) || (v >= 48 && v <= 51) ||
            (v >= 56 && v <= 57) || (v >= 60 && v <= 64) || (v >= 70 && v <= 78))
            return CLS_RED;
        if ((v >= 7 && v <= 11) || (v >= 40 && v <= 47) || (v >= 52 && v <= 55) ||
            (v >= 58 && v <= 59) || (v >= 65 && v <= 69) || (v >= 79 && v <= 87))
            return CLS_BLUE;
        if (v <= 31)
            return CLS_WHITE;
        return CLS_NONE;
    endfunction

    function automatic logic is_blinkable(input logic [RAM_DATA_WIDTH-1:0] t);
        int unsigned v;
        v = int'(t);
        return (v >= 70 && v <= 87);
    endfunction

    // Shifting the column to the MSB keeps the leftmost pixel in bit 31
    assign row_shifted  = rom_data_i << s1_col;
    assign pix_bit      = row_shifted[ROM_DATA_WIDTH-1];
    assign s1_class     = classify(s1_type);
    assign s1_blinkable = is_blinkable(s1_type);
    assign blink_off    = frame_cnt[5] && s1_blinkable;

    always_comb begin
        rgb_next = COL_BLACK;
        if (s1_video_on && pix_bit && !blink_off) begin
            case (s1_class)
                CLS_RED:   rgb_next = COL_RED;
                CLS_BLUE:  rgb_next = COL_BLUE;
                CLS_WHITE: rgb_next = COL_WHITE;
                default:   rgb_next = COL_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_video_on <= 1'b0;
            s1_hsync    <= 1'b1;
            s1_vsync    <= 1'b1;
            s1_col      <= '0;
            s1_type     <= '0;
            frame_cnt   <= '0;
            vsync_prev  <= 1'b1;
            rgb_o       <= '0;
            hsync_o     <= 1'b1;
            vsync_o     <= 1'b1;
        end else if (pix_en_i) begin
            s1_video_on <= video_on_i;
            s1_hsync    <= hsync_i;
            s1_vsync    <= vsync_i;
            s1_col      <= h_cntr_mod32_i;
            s1_type     <= tile_type_i;
            vsync_prev  <= vsync_i;
            // Blink reads the pre-update count, so a new frame only affects later pixels
            if (vsync_prev && !vsync_i)
                frame_cnt <= frame_cnt + 6'd1;
            rgb_o       <= rgb_next;
            hsync_o     <= s1_hsync;
            vsync_o     <= s1_vsync;
        end
    end

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Bench for tile_pixel_renderer: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model driven by the input history.
module tb_tile_pixel_renderer;

    logic        clk;
    logic        rst_n;
    logic        pix_en;
    logic        video_on;
    logic        hs;
    logic        vs;
    logic [4:0]  col;
    logic [6:0]  ttype;
    logic [31:0] rom;
    logic [11:0] rgb;
    logic        hs_o;
    logic        vs_o;

    int total = 0;
    int bad   = 0;

    tile_pixel_renderer #(
        .RAM_DATA_WIDTH(7),
        .ROM_DATA_WIDTH(32),
        .COLOR_WIDTH(12)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .pix_en_i(pix_en),
        .video_on_i(video_on),
        .hsync_i(hs),
        .vsync_i(vs),
        .h_cntr_mod32_i(col),
        .tile_type_i(ttype),
        .rom_data_i(rom),
        .rgb_o(rgb),
        .hsync_o(hs_o),
        .vsync_o(vs_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Colour table built from the listed type ranges
    logic [11:0] color_tab [128];

    task automatic fill(input int lo, input int hi, input logic [11:0] c);
        for (int i = lo; i <= hi; i++) color_tab[7'(i)] = c;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) color_tab[7'(i)] = 12'h000;
        fill(2, 6, 12'hF00);   fill(32, 39, 12'hF00); fill(48, 51, 12'hF00);
        fill(56, 57, 12'hF00); fill(60, 64, 12'hF00); fill(70, 78, 12'hF00);
        fill(7, 11, 12'h00F);  fill(40, 47, 12'h00F); fill(52, 55, 12'h00F);
        fill(58, 59, 12'h00F); fill(65, 69, 12'h00F); fill(79, 87, 12'h00F);
        fill(0, 1, 12'hFFF);   fill(12, 31, 12'hFFF);
    end

    function automatic logic [11:0] model_pixel(input logic v, input logic [6:0] t,
                                                input logic [4:0] c, input logic [31:0] row,
                                                input logic [5:0] frames_seen);
        if (!v) return 12'h000;
        if (row[5'd31 - c] == 1'b0) return 12'h000;
        if (frames_seen >= 6'd32 && t >= 7'd70 && t <= 7'd87) return 12'h000;
        return color_tab[t];
    endfunction

    // Model: output of a tick is the pixel described by the previous tick's controls
    // and this tick's row; frames counts vsync falling edges seen before this tick.
    logic        l_video;
    logic        l_hs;
    logic        l_vs;
    logic [4:0]  l_col;
    logic [6:0]  l_type;
    logic [5:0]  frames;
    logic [11:0] m_rgb;
    logic        m_hs;
    logic        m_vs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_video <= 1'b0;
            l_hs    <= 1'b1;
            l_vs    <= 1'b1;
            l_col   <= 5'd0;
            l_type  <= 7'd0;
            frames  <= 6'd0;
            m_rgb   <= 12'h000;
            m_hs    <= 1'b1;
            m_vs    <= 1'b1;
        end else if (pix_en) begin
            m_rgb   <= model_pixel(l_video, l_type, l_col, rom, frames);
            m_hs    <= l_hs;
            m_vs    <= l_vs;
            if (l_vs && !vs) frames <= frames + 6'd1;
            l_video <= video_on;
            l_hs    <= hs;
            l_vs    <= vs;
            l_col   <= col;
            l_type  <= ttype;
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %03h want %03h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rgb_vs_model", rgb, m_rgb);
        check("hsync_vs_model", {11'd0, hs_o}, {11'd0, m_hs});
        check("vsync_vs_model", {11'd0, vs_o}, {11'd0, m_vs});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] seq_exp [8];

    initial begin
        rst_n = 1'b1; pix_en = 1'b1; video_on = 1'b0; hs = 1'b1; vs = 1'b1;
        col = 5'd0; ttype = 7'd0; rom = 32'd0;
        #2 rst_n = 1'b0;
        step();
        step();
        check("reset_rgb", rgb, 12'h000);
        check("reset_hsync", {11'd0, hs_o}, 12'h001);
        check("reset_vsync", {11'd0, vs_o}, 12'h001);
        rst_n = 1'b1;

        // Test 1: column select, MSB is leftmost
        ttype = 7'd1; rom = 32'h8000_0001; video_on = 1'b1; col = 5'd0;
        step();
        col = 5'd31;
        step();
        check("t1_col0", rgb, 12'hFFF);
        col = 5'd5;
        step();
        check("t1_col31", rgb, 12'hFFF);
        step();
        check("t1_col5", rgb, 12'h000);

        // Test 2: blanking and sync delay
        video_on = 1'b0; ttype = 7'd2; rom = 32'hFFFF_FFFF;
        repeat (3) step();
        check("t2_blank", rgb, 12'h000);
        hs = 1'b0;
        step();
        check("t2_hs_1tick", {11'd0, hs_o}, 12'h001);
        step();
        check("t2_hs_2tick", {11'd0, hs_o}, 12'h000);
        hs = 1'b1; vs = 1'b0;
        step();
        check("t2_vs_1tick", {11'd0, vs_o}, 12'h001);
        step();
        check("t2_vs_2tick", {11'd0, vs_o}, 12'h000);
        check("t2_hs_back", {11'd0, hs_o}, 12'h001);
        vs = 1'b1;

        // Test 3: pix_en freeze mid-line, A5 = 1010_0101 across columns 0..7
        seq_exp = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        video_on = 1'b1; ttype = 7'd20; rom = 32'hA5A5_0F0F;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) col = 5'(k);
            step();
            if (k >= 1) check("t3_seq", rgb, seq_exp[k-1]);
            if (k == 4) begin
                pix_en = 1'b0;
                repeat (10) step();
                check("t3_frozen", rgb, seq_exp[3]);
                pix_en = 1'b1;
            end
        end

        // Test 4: blink over a full 64-frame cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ttype = 7'd75; video_on = 1'b1; rom = 32'hFFFF_FFFF; hs = 1'b1; vs = 1'b1; col = 5'd9;
        for (int f = 0; f <= 64; f++) begin
            repeat (3) step();
            check("t4_blink", rgb, ((f % 64) < 32) ? 12'hF00 : 12'h000);
            vs = 1'b0;
            step();
            vs = 1'b1;
        end

        // Test 5: type classes
        ttype = 7'd100;
        repeat (3) step();
        check("t5_type100", rgb, 12'h000);
        ttype = 7'd45;
        repeat (3) step();
        check("t5_type45", rgb, 12'h00F);
        ttype = 7'd20;
        repeat (3) step();
        check("t5_type20", rgb, 12'hFFF);

        // Test 6: asynchronous reset between edges
        hs = 1'b0; vs = 1'b0;
        repeat (3) step();
        check("t6_pre_rgb", rgb, 12'hFFF);
        check("t6_pre_hs", {11'd0, hs_o}, 12'h000);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rgb", rgb, 12'h000);
        check("t6_rst_hs", {11'd0, hs_o}, 12'h001);
        check("t6_rst_vs", {11'd0, vs_o}, 12'h001);
        #2 rst_n = 1'b1;
        step();
        check("t6_tick1_rgb", rgb, 12'h000);
        check("t6_tick1_hs", {11'd0, hs_o}, 12'h001);
        step();
        check("t6_tick2_rgb", rgb, 12'hFFF);
        check("t6_tick2_hs", {11'd0, hs_o}, 12'h000);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pix_en   = ($urandom_range(9) < 7);
            video_on = ($urandom_range(7) != 0);
            hs       = ($urandom_range(3) != 0);
            vs       = ($urandom_range(1) != 0);
            col      = 5'($urandom_range(31));
            ttype    = ($urandom_range(2) == 0) ? 7'(70 + $urandom_range(17)) : 7'($urandom_range(127));
            rom      = $urandom;
            step();
        end

        pix_en = 1'b1;
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
